decode_stage_pipe: RTL and testbench

//  Parametrised ID stage for the pipelined core: decodes one instruction per cycle and reads operands from an internal register file.

---
 rtl/decode_stage_pipe_pkg.sv | 88 ++++++++
 rtl/decode_stage_pipe_hazard_unit.sv | 30 +++
 rtl/decode_stage_pipe.sv | 119 +++++++++++
 tb/tb_decode_stage_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pipe_pkg.sv
// Shared types, opcode constants and decode helpers for the ID stage.
package decode_stage_pipe_pkg;

    // Width of the data fields carried in the ID/EX bundle.
    localparam int DATA_W = 32;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
    typedef enum logic       {ALU_SRC_RS2, ALU_SRC_IMM}                    alu_src_t;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4}                   result_src_t;
    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JAL, PC_JALR}          pc_src_t;

    // pc_update marks unconditional redirects (jumps); branch marks conditional ones.
    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              pc_update;
        logic              alu_a_pc;
        alu_src_t          alu_src;
        result_src_t       result_src;
        pc_src_t           pc_src;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] pc_cur;
    } id_to_ex_t;

    function automatic logic [DATA_W-1:0] imm_extend(input logic [31:0] instr, input imm_t sel);
        case (sel)
            IMM_I:   return {{20{instr[31]}}, instr[31:20]};
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // Field extraction and control decode; operands and PC are filled in by the caller.
    // Unknown opcodes fall through with all controls cleared, i.e. a NOP.
    function automatic id_to_ex_t decode_instr(input logic [31:0] instr);
        id_to_ex_t b;
        imm_t      sel;
        b        = '0;
        sel      = IMM_NONE;
        b.funct3 = instr[14:12];
        b.funct7 = instr[31:25];
        b.rs1    = instr[19:15];
        b.rs2    = instr[24:20];
        b.rd     = instr[11:7];
        case (instr[6:0])
            OPC_LUI:    begin b.reg_write = 1'b1; b.alu_src = ALU_SRC_IMM; sel = IMM_U; end
            OPC_AUIPC:  begin b.reg_write = 1'b1; b.alu_src = ALU_SRC_IMM; b.alu_a_pc = 1'b1; sel = IMM_U; end
            OPC_JAL:    begin b.reg_write = 1'b1; b.pc_update = 1'b1; b.result_src = RES_PC4;
                              b.pc_src = PC_JAL; sel = IMM_J; end
            OPC_JALR:   begin b.reg_write = 1'b1; b.pc_update = 1'b1; b.result_src = RES_PC4;
                              b.pc_src = PC_JALR; b.alu_src = ALU_SRC_IMM; sel = IMM_I; end
            OPC_BRANCH: begin b.branch = 1'b1; b.pc_src = PC_BRANCH; sel = IMM_B; end
            OPC_LOAD:   begin b.reg_write = 1'b1; b.mem_read = 1'b1; b.alu_src = ALU_SRC_IMM;
                              b.result_src = RES_MEM; sel = IMM_I; end
            OPC_STORE:  begin b.mem_write = 1'b1; b.alu_src = ALU_SRC_IMM; sel = IMM_S; end
            OPC_OP_IMM: begin b.reg_write = 1'b1; b.alu_src = ALU_SRC_IMM; sel = IMM_I; end
            OPC_OP:     begin b.reg_write = 1'b1; end
            default:    ;
        endcase
        b.imm_ext = imm_extend(instr, sel);
        return b;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_hazard_unit.sv
// Load-use hazard detection: which source registers the ID instruction reads,
// compared against the destination of a load sitting in EX.
module decode_stage_pipe_hazard_unit
    import decode_stage_pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [6:0]    opcode_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic          ex_is_load_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          out_valid_i,
    output logic          hazard_o
);

    logic rs1_used;
    logic rs2_used;

    // Source-use decode and compare against the EX load destination.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        rs1_used = !(opcode_i inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        rs2_used = opcode_i inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        hazard_o = ex_is_load_i && (ex_rd_i != '0) && out_valid_i &&
                   ((rs1_used && (int'(rs1_i) == int'(ex_rd_i))) ||
                    (rs2_used && (int'(rs2_i) == int'(ex_rd_i))));
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: decode, register-file read with optional WB bypass, valid/ready
// handshake, load-use stalling, flush and a saturating stall counter.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int  XLEN        = DATA_W,
    parameter int  NREGS       = 32,
    parameter bit  BYPASS_WB   = 1'b1,
    parameter int  STALL_CNT_W = 16,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   flush,
    input  logic                   ex_is_load,
    input  logic [AW-1:0]          ex_rd,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output id_to_ex_t              out_bundle,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [XLEN-1:0]        rf_q [NREGS];
    logic                   valid_q, valid_d;
    id_to_ex_t              bundle_q, bundle_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    id_to_ex_t              dec;
    logic                   hazard;
    logic                   accept;
    logic [XLEN-1:0]        rs1_stored, rs2_stored;

    // x0 reads as zero; with BYPASS_WB a same-cycle writeback wins over the stored value.
    function automatic logic [XLEN-1:0] read_operand(input logic [4:0] rs, input logic [XLEN-1:0] stored,
                                                     input logic we, input logic [AW-1:0] wrd,
                                                     input logic [XLEN-1:0] wdata);
        if (rs == 5'd0) return '0;
        if (BYPASS_WB && we && (int'(wrd) == int'(rs))) return wdata;
        return stored;
    endfunction

    decode_stage_pipe_hazard_unit #(.AW(AW)) u_hazard (
        .opcode_i     (in_instr[6:0]),
        .rs1_i        (in_instr[19:15]),
        .rs2_i        (in_instr[24:20]),
        .ex_is_load_i (ex_is_load),
        .ex_rd_i      (ex_rd),
        .out_valid_i  (valid_q),
        .hazard_o     (hazard)
    );

    assign in_ready = flush || (!hazard && (!valid_q || out_ready));
    assign accept   = in_valid && in_ready && !flush;

    // Decode the IF/ID instruction and read its operands every cycle.
    always_comb begin
        rs1_stored = (int'(in_instr[19:15]) < NREGS) ? rf_q[AW'(in_instr[19:15])] : '0;
        rs2_stored = (int'(in_instr[24:20]) < NREGS) ? rf_q[AW'(in_instr[24:20])] : '0;
        dec        = decode_instr(in_instr);
        dec.rd1    = DATA_W'(read_operand(in_instr[19:15], rs1_stored, wb_we, wb_rd, wb_data));
        dec.rd2    = DATA_W'(read_operand(in_instr[24:20], rs2_stored, wb_we, wb_rd, wb_data));
        dec.pc_cur = DATA_W'(in_pc);
    end

    // Next-state selection for the ID/EX register, in priority order.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        stall_d  = stall_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (hazard && out_ready) begin
            valid_d = 1'b0;
            if (stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
        end else if (valid_q && !out_ready) begin
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register and stall counter.
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            stall_q  <= stall_d;
        end
    end

    // Register file write port; writes continue through stalls and flushes.
    // NOTE: the register file is built from flops and cleared on reset, so it cannot map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_we && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign out_valid    = valid_q;
    assign out_bundle   = bundle_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized and directed bench for decode_stage_pipe. Two instances share the
// stimulus: the default configuration, and one with BYPASS_WB=0 and a narrow
// stall counter so saturation is reachable in a short run.
module tb_decode_stage_pipe;
    import decode_stage_pipe_pkg::*;

    localparam logic [6:0] C_LOAD = 7'h03, C_OPIMM = 7'h13, C_AUIPC = 7'h17, C_STORE = 7'h23,
                           C_OP = 7'h33, C_LUI = 7'h37, C_BRANCH = 7'h63, C_JALR = 7'h67,
                           C_JAL = 7'h6F;
    localparam int NB_W = 5;

    logic        clk = 1'b0;
    logic        rst, iv, fl, exl, wbwe, ordy;
    logic [31:0] ins, pc, wbdata;
    logic [4:0]  exrd, wbrd;

    logic            rdy_a, rdy_b, ov_a, ov_b;
    id_to_ex_t       ob_a, ob_b;
    logic [15:0]     st_a;
    logic [NB_W-1:0] st_b;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic        m_valid, m_zero;
    logic [4:0]  m_ctl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_imm, m_pc, m_rd1_a, m_rd2_a, m_rd1_b, m_rd2_b;
    int          m_stall;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy_a), .in_instr(ins), .in_pc(pc),
        .flush(fl), .ex_is_load(exl), .ex_rd(exrd), .wb_we(wbwe), .wb_rd(wbrd), .wb_data(wbdata),
        .out_valid(ov_a), .out_ready(ordy), .out_bundle(ob_a), .stall_cycles(st_a)
    );

    decode_stage_pipe #(.BYPASS_WB(1'b0), .STALL_CNT_W(NB_W)) dut_nb (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy_b), .in_instr(ins), .in_pc(pc),
        .flush(fl), .ex_is_load(exl), .ex_rd(exrd), .wb_we(wbwe), .wb_rd(wbrd), .wb_data(wbdata),
        .out_valid(ov_b), .out_ready(ordy), .out_bundle(ob_b), .stall_cycles(st_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] rs, input bit byp);
        if (rs == 0) return 32'd0;
        if (byp && wbwe && wbrd == rs) return wbdata;
        return rf[rs];
    endfunction

    function automatic logic [31:0] m_immediate(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op inside {C_OPIMM, C_LOAD, C_JALR}) return 32'($signed(i[31:20]));
        if (op == C_STORE)  return 32'($signed({i[31:25], i[11:7]}));
        if (op == C_BRANCH) return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        if (op inside {C_LUI, C_AUIPC}) return i & 32'hFFFF_F000;
        if (op == C_JAL)    return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        return 32'd0;
    endfunction

    // Advance the reference by one clock using the currently driven inputs.
    task automatic model_step(output logic exp_rdy);
        logic [6:0] op;
        logic       u1, u2, haz, acc;
        op = ins[6:0];
        exp_rdy = 1'b1;
        if (rst) begin
            m_valid = 0; m_zero = 1; m_ctl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0;
            m_imm = 0; m_pc = 0; m_rd1_a = 0; m_rd2_a = 0; m_rd1_b = 0; m_rd2_b = 0; m_stall = 0;
            for (int r = 0; r < 32; r++) rf[r] = 32'd0;
            return;
        end
        u1  = !(op inside {C_LUI, C_AUIPC, C_JAL});
        u2  = op inside {C_OP, C_STORE, C_BRANCH};
        haz = exl && exrd != 0 && m_valid && ((u1 && ins[19:15] == exrd) || (u2 && ins[24:20] == exrd));
        exp_rdy = fl || (!haz && (!m_valid || ordy));
        acc = iv && exp_rdy && !fl;
        if (fl) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_zero = 0;
            m_ctl = {op inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP},
                     op == C_LOAD, op == C_STORE, op == C_BRANCH, op inside {C_JAL, C_JALR}};
            m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7];
            m_f3 = ins[14:12]; m_f7 = ins[31:25]; m_imm = m_immediate(ins); m_pc = pc;
            m_rd1_a = m_read(ins[19:15], 1); m_rd2_a = m_read(ins[24:20], 1);
            m_rd1_b = m_read(ins[19:15], 0); m_rd2_b = m_read(ins[24:20], 0);
        end else if (haz && ordy) begin
            m_valid = 0; m_stall++;
        end else if (!(m_valid && !ordy)) m_valid = 0;
        if (wbwe && wbrd != 0) rf[wbrd] = wbdata;
    endtask

    // One clock: inputs are already driven (just after a negedge).
    task automatic tick();
        logic exp_rdy;
        logic [29:0] ectl;
        #1;
        model_step(exp_rdy);
        if (!rst) begin
            check("in_ready", rdy_a, exp_rdy);
            check("in_ready_nb", rdy_b, exp_rdy);
        end
        @(posedge clk);
        #1;
        check("out_valid", ov_a, m_valid);
        check("out_valid_nb", ov_b, m_valid);
        check("stall_cycles", st_a, (m_stall > 65535) ? 65535 : m_stall);
        check("stall_cycles_nb", st_b, (m_stall > 31) ? 31 : m_stall);
        if (m_valid || m_zero) begin
            ectl = {m_ctl, m_rs1, m_rs2, m_rd, m_f3, m_f7};
            check("ctl", {ob_a.reg_write, ob_a.mem_read, ob_a.mem_write, ob_a.branch, ob_a.pc_update,
                          ob_a.rs1, ob_a.rs2, ob_a.rd, ob_a.funct3, ob_a.funct7}, ectl);
            check("ctl_nb", {ob_b.reg_write, ob_b.mem_read, ob_b.mem_write, ob_b.branch, ob_b.pc_update,
                             ob_b.rs1, ob_b.rs2, ob_b.rd, ob_b.funct3, ob_b.funct7}, ectl);
            check("imm_ext", ob_a.imm_ext, m_imm);
            check("pc_cur", ob_a.pc_cur, m_pc);
            check("rd1", ob_a.rd1, m_rd1_a);
            check("rd2", ob_a.rd2, m_rd2_a);
            check("rd1_nb", ob_b.rd1, m_rd1_b);
            check("rd2_nb", ob_b.rd2, m_rd2_b);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; iv = 0; ins = 32'h0000_0013; pc = 32'h0; fl = 0; exl = 0; exrd = 0;
        wbwe = 0; wbrd = 0; wbdata = 0; ordy = 1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, C_OP};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, C_OPIMM};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [6:0] op;
        ops = '{C_LOAD, C_OPIMM, C_AUIPC, C_STORE, C_OP, C_LUI, C_BRANCH, C_JALR, C_JAL, 7'h00};
        op = ops[$urandom_range(0, 9)];
        if (op == 7'h00) op = 7'($urandom);
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), op};
    endfunction

    initial begin
        idle();
        // Reset held with a valid instruction pending
        rst = 1; iv = 1; ins = enc_addi(5'd1, 5'd0, 12'd9);
        repeat (3) tick();
        idle();
        tick();

        // Straight line with WB landing on the reading cycle
        iv = 1; ins = enc_addi(5'd1, 5'd0, 12'd5); pc = 32'h100;
        tick();
        ins = enc_r(5'd2, 5'd1, 5'd1); pc = 32'h104; wbwe = 1; wbrd = 5'd1; wbdata = 32'd5;
        tick();
        check("bypass_rd1", ob_a.rd1, 32'd5);
        check("bypass_rd2", ob_a.rd2, 32'd5);
        check("nobypass_rd1", ob_b.rd1, 32'd0);

        // Load-use: lw x3 in EX, add x4,x3,x0 in ID
        wbwe = 0; ins = enc_r(5'd4, 5'd3, 5'd0); pc = 32'h108; exl = 1; exrd = 5'd3;
        tick();
        check("loaduse_bubble", ov_a, 1'b0);
        check("loaduse_stall", st_a, 16'd1);
        exl = 0;
        tick();
        check("loaduse_resume", ov_a, 1'b1);

        // Flush with valid output and valid input
        fl = 1; ins = enc_addi(5'd9, 5'd0, 12'd1); pc = 32'h10C;
        tick();
        check("flush_valid", ov_a, 1'b0);
        check("flush_stall", st_a, 16'd1);
        fl = 0;

        // Backpressure with a WB write to x5 landing during the hold
        ins = enc_addi(5'd7, 5'd0, 12'h055); pc = 32'h110;
        tick();
        ordy = 0; ins = enc_r(5'd6, 5'd5, 5'd5); pc = 32'h114;
        for (int k = 0; k < 4; k++) begin
            wbwe = (k == 1); wbrd = 5'd5; wbdata = 32'h1234_5678;
            tick();
            check("hold_imm", ob_a.imm_ext, 32'h55);
        end
        wbwe = 0; ordy = 1;
        tick();
        check("x5_rd1", ob_a.rd1, 32'h1234_5678);
        check("x5_rd1_nb", ob_b.rd1, 32'h1234_5678);

        // Writes to x0 are ignored
        wbwe = 1; wbrd = 5'd0; wbdata = 32'hDEAD; ins = enc_r(5'd8, 5'd0, 5'd0);
        tick();
        wbwe = 0;
        tick();
        check("x0_read", ob_a.rd1, 32'd0);

        // Saturation of the narrow counter: 2^NB_W+2 stall cycles
        ins = enc_r(5'd4, 5'd3, 5'd0); exrd = 5'd3;
        for (int k = 0; k < (1 << NB_W) + 2; k++) begin
            exl = 0; tick();
            exl = 1; tick();
        end
        exl = 0;
        check("sat_nb", st_b, 5'h1F);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 255) == 0);
            iv     = ($urandom_range(0, 3) != 0);
            ins    = rand_instr();
            pc     = $urandom;
            fl     = ($urandom_range(0, 9) == 0);
            exl    = ($urandom_range(0, 2) == 0);
            exrd   = 5'($urandom_range(0, 7));
            wbwe   = ($urandom_range(0, 1) == 0);
            wbrd   = 5'($urandom_range(0, 7));
            wbdata = $urandom;
            ordy   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
